l2_arbiter: RTL and testbench

Two-port arbiter that shares the single CPU-side port of the unified L2 cache between the instruction L1 and the data L1. It sits between both L1 miss paths and `l2_cache`. It grants one requester at a time and latches that requester's line request into registers, so the L2 sees a stable request. It then routes `l2_resp` back to the winner only.

---
 rtl/l2_arbiter_pkg.sv | 5 +
 rtl/l2_arbiter.sv | 94 +++++++++
 tb/tb_l2_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg: shared state and requester encodings for cache-port arbiters
package l2_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} requester_t;
endpackage

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single L2 CPU-side port between the instruction and data L1 miss paths
// Ports: i_* instruction L1 (read only), d_* data L1 (read/write-back), l2_* to/from l2_cache.
// The granted request is latched, so l2_* never depends combinationally on i_*/d_*.
// Define L2_ARB_ROUND_ROBIN_EN to alternate ties via last_grant; otherwise D always wins ties.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_address,
  input  logic              i_read,
  output logic [s_line-1:0] i_rdata256,
  output logic              i_resp,
  input  logic [31:0]       d_address,
  input  logic [s_line-1:0] d_wdata256,
  input  logic              d_read,
  input  logic              d_write,
  output logic [s_line-1:0] d_rdata256,
  output logic              d_resp,
  output logic [31:0]       l2_address,
  output logic [s_line-1:0] l2_wdata256,
  output logic              l2_read,
  output logic              l2_write,
  input  logic [s_line-1:0] l2_rdata256,
  input  logic              l2_resp
);
  arb_state_t state, state_n;
  requester_t win;
  logic [31:0] req_addr, addr_n;
  logic [s_line-1:0] req_wdata, wdata_n;
  logic req_rd, rd_n, req_wr, wr_n, busy;
`ifdef L2_ARB_ROUND_ROBIN_EN
  requester_t last_grant, last_n;
  // a tie goes to whichever side was not served last
  assign win = (i_read && !((d_read || d_write) && last_grant == REQ_I)) ? REQ_I : REQ_D;
`else
  assign win = (i_read && !(d_read || d_write)) ? REQ_I : REQ_D;
`endif
  always_comb begin
    state_n = state;
    addr_n  = req_addr;
    wdata_n = req_wdata;
    rd_n    = req_rd;
    wr_n    = req_wr;
`ifdef L2_ARB_ROUND_ROBIN_EN
    last_n  = last_grant;
`endif
    if (state == IDLE && (i_read || d_read || d_write)) begin
      state_n = win == REQ_I ? SERVE_I : SERVE_D;
      addr_n  = win == REQ_I ? i_address : d_address;
      wdata_n = win == REQ_I ? '0 : d_wdata256;
      // a D grant here implies d_read or d_write, so !d_write means a read; write beats read
      rd_n    = win == REQ_I || !d_write;
      wr_n    = win == REQ_D && d_write;
    end else if (state != IDLE && l2_resp) begin
      state_n = IDLE;
`ifdef L2_ARB_ROUND_ROBIN_EN
      last_n  = state == SERVE_I ? REQ_I : REQ_D;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_wdata <= '0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
`ifdef L2_ARB_ROUND_ROBIN_EN
      last_grant <= REQ_I;
`endif
    end else begin
      state     <= state_n;
      req_addr  <= addr_n;
      req_wdata <= wdata_n;
      req_rd    <= rd_n;
      req_wr    <= wr_n;
`ifdef L2_ARB_ROUND_ROBIN_EN
      last_grant <= last_n;
`endif
    end
  end
  assign busy        = state != IDLE;
  assign l2_address  = busy ? req_addr : '0;
  assign l2_wdata256 = busy ? req_wdata : '0;
  assign l2_read     = busy && req_rd;
  assign l2_write    = busy && req_wr;
  assign i_resp      = state == SERVE_I && l2_resp;
  assign d_resp      = state == SERVE_D && l2_resp;
  assign i_rdata256  = l2_rdata256;
  assign d_rdata256  = l2_rdata256;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: randomized scoreboard bench for l2_arbiter with an in-bench arbitration model
module tb_l2_arbiter;
  localparam int SL = 256;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] i_address = '0, d_address = '0, l2_address;
  logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, l2_resp = 1'b0;
  logic [SL-1:0] d_wdata256 = '0, l2_rdata256 = '0, i_rdata256, d_rdata256, l2_wdata256;
  logic i_resp, d_resp, l2_read, l2_write;
  typedef struct {
    bit d;
    logic [31:0] addr;
    logic [SL-1:0] wdata;
    bit rd;
    bit wr;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur, m_e;
  bit have_cur = 0, busy_m = 0, who_m = 0, last_m = 0, m_dw;
  bit i_done = 0, d_done = 0, run = 1, resp_en = 1;
  int lat = -1;
  int total = 0, bad = 0;
  l2_arbiter #(.s_line(SL)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata256(i_rdata256), .i_resp(i_resp),
    .d_address(d_address), .d_wdata256(d_wdata256), .d_read(d_read), .d_write(d_write),
    .d_rdata256(d_rdata256), .d_resp(d_resp),
    .l2_address(l2_address), .l2_wdata256(l2_wdata256), .l2_read(l2_read), .l2_write(l2_write),
    .l2_rdata256(l2_rdata256), .l2_resp(l2_resp)
  );
  always #5 clk = ~clk;
  function automatic logic [SL-1:0] rand_line();
    logic [SL-1:0] r;
    for (int k = 0; k < SL / 32; k++) r[k*32+:32] = $urandom;
    return r;
  endfunction
  task automatic chk(input string name, input logic [SL-1:0] act, input logic [SL-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, req);
    end
  endtask
  always @(posedge clk) begin
    i_done <= i_resp;
    d_done <= d_resp;
  end
  // reference: one transaction at a time; a pending request is arbitrated on the first
  // edge where the port is free, then the port is held until the edge that sees l2_resp
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      busy_m = 0;
      last_m = 0;
    end else if (busy_m) begin
      if (l2_resp) begin
        busy_m = 0;
        last_m = who_m;
      end
    end else if (i_read || d_read || d_write) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
      m_dw = (d_read || d_write) && (!i_read || last_m == 0);
`else
      m_dw = d_read || d_write;
`endif
      who_m = m_dw;
      busy_m = 1;
      m_e.d = m_dw;
      m_e.addr = m_dw ? d_address : i_address;
      m_e.wdata = m_dw ? d_wdata256 : '0;
      m_e.rd = m_dw ? !d_write : 1'b1;
      m_e.wr = m_dw ? d_write : 1'b0;
      exp_q.push_back(m_e);
    end
  end
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      have_cur = 0;
      chk("rst_l2_read", SL'(l2_read), '0);
      chk("rst_l2_write", SL'(l2_write), '0);
      chk("rst_l2_address", SL'(l2_address), '0);
      chk("rst_resp", SL'({i_resp, d_resp}), '0);
    end else begin
      if ((l2_read || l2_write) && !have_cur) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_request @%0t: got l2 request want none", $time);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
        end
      end else if (!(l2_read || l2_write) && exp_q.size() != 0) begin
        total++;
        bad++;
        $display("FAIL grant_latency @%0t: got no l2 request want one", $time);
      end
      if (have_cur) begin
        chk("l2_address", SL'(l2_address), SL'(cur.addr));
        chk("l2_wdata256", l2_wdata256, cur.wdata);
        chk("l2_read", SL'(l2_read), SL'(cur.rd));
        chk("l2_write", SL'(l2_write), SL'(cur.wr));
        chk("i_resp", SL'(i_resp), SL'(l2_resp && !cur.d));
        chk("d_resp", SL'(d_resp), SL'(l2_resp && cur.d));
        if (l2_resp) begin
          chk(cur.d ? "d_rdata256" : "i_rdata256", cur.d ? d_rdata256 : i_rdata256, l2_rdata256);
          have_cur = 0;
        end
      end else begin
        chk("idle_l2", SL'({l2_read, l2_write, l2_address}), '0);
        chk("idle_wdata", l2_wdata256, '0);
        chk("idle_resp", SL'({i_resp, d_resp}), '0);
      end
    end
  end
  task automatic drive();
    logic [1:0] op;
    if (l2_resp) l2_resp = 1'b0;
    else if (resp_en && (l2_read || l2_write)) begin
      if (lat < 0) lat = $urandom_range(0, 3);
      if (lat == 0) begin
        l2_resp = 1'b1;
        l2_rdata256 = rand_line();
        lat = -1;
      end else lat--;
    end
    if (i_read && i_done) i_read = 1'b0;
    else if (!i_read) begin
      if (run && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_address = $urandom;
      end
    end else if ($urandom_range(0, 3) == 0) i_address = $urandom;
    if ((d_read || d_write) && d_done) {d_read, d_write} = 2'b00;
    else if (!(d_read || d_write)) begin
      if (run && $urandom_range(0, 2) == 0) begin
        op = 2'($urandom_range(1, 3));
        {d_write, d_read} = op;
        d_address = $urandom;
        d_wdata256 = rand_line();
      end
    end else if ($urandom_range(0, 3) == 0) begin
      d_address = $urandom;
      d_wdata256 = rand_line();
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", SL'({l2_read, l2_write, i_resp, d_resp}), '0);
    rst = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      drive();
    end
    run = 0;
    repeat (60) begin
      @(negedge clk);
      drive();
    end
    chk("drain1", SL'({have_cur, exp_q.size() != 0}), '0);
    resp_en = 0;
    @(negedge clk);
    d_write = 1'b1;
    d_address = 32'h8000_0040;
    d_wdata256 = rand_line();
    @(negedge clk);
    #1;
    chk("wb_l2_write", SL'({l2_write, l2_read}), SL'(2'b10));
    d_address = 32'h0000_0200;
    @(negedge clk);
    #1;
    chk("wb_addr_held", SL'(l2_address), SL'(32'h8000_0040));
    l2_resp = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_l2_write", SL'(l2_write), '0);
    chk("midrst_d_resp", SL'(d_resp), '0);
    l2_resp = 1'b0;
    {d_read, d_write} = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_en = 1;
    i_read = 1'b1;
    i_address = 32'h0000_1000;
    d_read = 1'b1;
    d_address = 32'h0000_0100;
    @(negedge clk);
    #1;
    chk("first_tie_d", SL'({l2_read, l2_address}), SL'({1'b1, 32'h0000_0100}));
    run = 1;
    repeat (2000) begin
      @(negedge clk);
      drive();
    end
    run = 0;
    repeat (60) begin
      @(negedge clk);
      drive();
    end
    chk("drain2", SL'({have_cur, exp_q.size() != 0}), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
